// File: rtl/repeated_subtract_divider_pkg.sv
// Shared definitions for the repeated-subtraction divider.
//   state_e       : FSM encoding (IDLE, SUB, DONE)
//   DEFAULT_WIDTH : default operand/result width
package repeated_subtract_divider_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/repeated_subtract_divider_sub_step.sv
// Combinational WIDTH-bit unsigned subtract step.
// Ports:
//   a, b      : unsigned operands
//   diff      : a - b, modulo 2^WIDTH
//   borrow_o  : 1 when a < b (borrow out of the subtract)
module sub_step
    import repeated_subtract_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_o
);

    // One extra bit catches the borrow as the MSB of the widened result.
    assign {borrow_o, diff} = {1'b0, a} - {1'b0, b};

endmodule

// File: rtl/repeated_subtract_divider.sv
// Unsigned divider by repeated subtraction: one subtract per clock while the
// running remainder is >= the captured divisor.
// Ports:
//   clk, reset_n          : clock, asynchronous active-low reset
//   start                 : request, sampled only in IDLE
//   dividend, divisor     : operands, captured when start is accepted
//   busy                  : high while subtracting (SUB)
//   done                  : one-cycle pulse, results valid
//   quotient, remainder   : registered results, held until next start
//   div_by_zero           : registered flag, valid with done
// Configuration:
//   DIV_ZERO_CHECK_EN defined   : divisor 0 finishes after one SUB cycle with
//                                 quotient all-ones and div_by_zero set.
//   DIV_ZERO_CHECK_EN undefined : div_by_zero is tied low; divisor 0 counts
//                                 the quotient up to all-ones, then finishes.
module repeated_subtract_divider
    import repeated_subtract_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             quo_full;

    sub_step #(.WIDTH(WIDTH)) u_sub_step (
        .a        (rem_q),
        .b        (dvs_q),
        .diff     (diff),
        .borrow_o (borrow)
    );

    // Saturation guard: stops a zero divisor from wrapping the quotient.
    assign quo_full = &quo_q;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start) state_d = SUB;
            SUB: begin
`ifdef DIV_ZERO_CHECK_EN
                if (dvs_q == '0)              state_d = DONE;
                else if (borrow || quo_full)  state_d = DONE;
`else
                if (borrow || quo_full)       state_d = DONE;
`endif
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (state_q == SUB);
        done = (state_q == DONE);
    end

    // Datapath next-state
`ifdef DIV_ZERO_CHECK_EN
    logic dbz_q, dbz_d;
`endif

    always_comb begin
        rem_d = rem_q;
        quo_d = quo_q;
        dvs_d = dvs_q;
`ifdef DIV_ZERO_CHECK_EN
        dbz_d = dbz_q;
`endif
        if (state_q == IDLE && start) begin
            rem_d = dividend;
            quo_d = '0;
            dvs_d = divisor;
`ifdef DIV_ZERO_CHECK_EN
            dbz_d = 1'b0;
`endif
        end else if (state_q == SUB) begin
`ifdef DIV_ZERO_CHECK_EN
            if (dvs_q == '0) begin
                quo_d = '1;
                dbz_d = 1'b1;
            end else if (!borrow && !quo_full) begin
                rem_d = diff;
                quo_d = quo_q + WIDTH'(1);
            end
`else
            if (!borrow && !quo_full) begin
                rem_d = diff;
                quo_d = quo_q + WIDTH'(1);
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvs_q <= dvs_d;
        end
    end

`ifdef DIV_ZERO_CHECK_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) dbz_q <= 1'b0;
        else          dbz_q <= dbz_d;
    end
    assign div_by_zero = dbz_q;
`else
    assign div_by_zero = 1'b0;
`endif

    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: tb/tb_repeated_subtract_divider.sv
module tb_repeated_subtract_divider;

    localparam int W    = 4;
    localparam int MAXV = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic [W-1:0] dividend, divisor;
    logic         busy, done, div_by_zero;
    logic [W-1:0] quotient, remainder;

    repeated_subtract_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int q;
        int r;
        int dbz;
        int lat;  // edges from accept to the edge that raises done
        int e0;   // cycle count right after the accepting edge
    } exp_t;

    exp_t sb[$];
    int n_cmp = 0;
    int n_err = 0;
    int last_q = 0, last_r = 0, last_dbz = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: plain integer division, plus the zero-divisor rules.
    function automatic exp_t model(input int a, input int b);
        exp_t e;
        e.e0 = 0;
        if (b == 0) begin
            e.q = MAXV;
            e.r = a;
`ifdef DIV_ZERO_CHECK_EN
            e.dbz = 1;
            e.lat = 1;
`else
            e.dbz = 0;
            e.lat = MAXV + 1;
`endif
        end else begin
            e.q   = a / b;
            e.r   = a % b;
            e.dbz = 0;
            e.lat = e.q + 1;
        end
        return e;
    endfunction

    // Monitor: timing of busy/done from the scoreboard head, values on done,
    // and held results while idle.
    always @(negedge clk) begin
        bit   exp_busy, exp_done;
        exp_t e;
        exp_busy = 1'b0;
        exp_done = 1'b0;
        if (sb.size() > 0) begin
            exp_busy = (cyc - sb[0].e0) < sb[0].lat;
            exp_done = (cyc - sb[0].e0) == sb[0].lat;
        end
        chk("busy", int'(busy), int'(exp_busy));
        chk("done", int'(done), int'(exp_done));
        if (exp_done) begin
            e = sb.pop_front();
            chk("quotient", int'(quotient), e.q);
            chk("remainder", int'(remainder), e.r);
            chk("div_by_zero", int'(div_by_zero), e.dbz);
            last_q = e.q; last_r = e.r; last_dbz = e.dbz;
        end else if (sb.size() == 0) begin
            chk("hold_quotient", int'(quotient), last_q);
            chk("hold_remainder", int'(remainder), last_r);
            chk("hold_div_by_zero", int'(div_by_zero), last_dbz);
        end
    end

    // One operation. noise: random start/operands while the op is in flight.
    // repulse: drive start with 5/5 so that it is sampled at edge 2.
    task automatic run_op(input int a, input int b, input bit noise, input bit repulse);
        exp_t e;
        @(negedge clk);
        start = 1'b1; dividend = W'(a); divisor = W'(b);
        @(posedge clk); #1;
        e = model(a, b);
        e.e0 = cyc;
        sb.push_back(e);
        forever begin
            @(negedge clk);
            if (cyc - e.e0 >= e.lat + 1) begin
                start = 1'b0;
                break;
            end
            if (noise) begin
                start    = 1'($urandom);
                dividend = W'($urandom);
                divisor  = W'($urandom);
            end else if (repulse && (cyc - e.e0 == 1)) begin
                start = 1'b1; dividend = 5; divisor = 5;
            end else begin
                start = 1'b0;
            end
        end
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(negedge clk);
        chk("rst_quotient", int'(quotient), 0);
        chk("rst_remainder", int'(remainder), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        run_op(13, 4, 1'b0, 1'b0);
        run_op(3, 5, 1'b0, 1'b0);
        run_op(15, 1, 1'b0, 1'b0);
        run_op(9, 0, 1'b0, 1'b0);
        run_op(0, 7, 1'b0, 1'b0);
        run_op(15, 15, 1'b0, 1'b0);
        run_op(0, 0, 1'b1, 1'b0);

        // Abort mid-SUB: 14/2, reset after edge 3.
        begin
            exp_t e;
            @(negedge clk);
            start = 1'b1; dividend = 14; divisor = 2;
            @(posedge clk); #1;
            e = model(14, 2);
            e.e0 = cyc;
            sb.push_back(e);
            @(negedge clk);
            start = 1'b0;
            repeat (3) @(posedge clk);
            #2;
            reset_n = 1'b0;
            sb.delete();
            last_q = 0; last_r = 0; last_dbz = 0;
            #1;
            chk("abort_quotient", int'(quotient), 0);
            chk("abort_remainder", int'(remainder), 0);
            chk("abort_busy", int'(busy), 0);
            chk("abort_done", int'(done), 0);
            repeat (2) @(negedge clk);
            reset_n = 1'b1;
        end
        run_op(7, 7, 1'b0, 1'b0);

        run_op(12, 3, 1'b0, 1'b1);

        for (int i = 0; i < 40; i++)
            run_op(int'($urandom_range(0, MAXV)), int'($urandom_range(0, MAXV)), 1'($urandom), 1'b0);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
